ram_sp_be: RTL

RAM_SP_BE -- requirements
Module: ram_sp_be

---
 rtl/ram_sp_be.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_sp_be.sv
// Single-port word RAM with per-byte write enables and a fixed-latency response pipeline.
// An optional zero-fill pass after reset runs before the first request is accepted.
module ram_sp_be #(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RAM_DEPTH     = 16000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  output logic                    o_rsp_valid,
  output logic                    o_read_ack,
  output logic                    o_write_ack,
  output logic                    o_err,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        init_cnt;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    accept_c;
  logic                    in_range_c;
  logic                    init_we_c;
  logic                    wr_c;
  logic [IDX_W-1:0]        idx_c;

  logic                    s1_valid;
  logic                    s1_read;
  logic                    s1_write;
  logic                    s1_err;
  logic [DATA_WIDTH-1:0]   s1_data;

  assign o_req_ready = ready_q;
  assign accept_c    = i_req_valid & ready_q & ~i_rst;
  assign in_range_c  = ({1'b0, i_address} < DEPTH_L);
  assign idx_c       = i_address[IDX_W-1:0];
  assign init_we_c   = ~i_rst & (state == S_INIT);
  assign wr_c        = accept_c & i_we & in_range_c;

  // Control: zero-fill sweep, then serve requests; ready is registered with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      init_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == LAST_IDX) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN:   ready_q <= 1'b1;
        default: state   <= S_RUN;
      endcase
    end
  end

  // Array write port, shared by the init sweep and byte-masked request writes; never reset.
  always_ff @(posedge i_clk) begin
    if (init_we_c) begin
      mem[init_cnt] <= '0;
    end else if (wr_c) begin
      for (int k = 0; k < int'(BE_W); k++) begin
        if (i_be[k]) mem[idx_c][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // First response stage: captures the request kind and read data at the accepting edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_write <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept_c;
      s1_read  <= accept_c & ~i_we;
      s1_write <= accept_c & i_we;
      s1_err   <= accept_c & ~in_range_c;
      if (accept_c & ~i_we) s1_data <= in_range_c ? mem[idx_c] : '0;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign o_rsp_valid = s1_valid;
      assign o_read_ack  = s1_read;
      assign o_write_ack = s1_write;
      assign o_err       = s1_err;
      assign o_rdata     = s1_data;
    end else begin : g_lat2
      // Extra stage; read data only advances on a read response so o_rdata holds otherwise.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          o_rsp_valid <= 1'b0;
          o_read_ack  <= 1'b0;
          o_write_ack <= 1'b0;
          o_err       <= 1'b0;
          o_rdata     <= '0;
        end else begin
          o_rsp_valid <= s1_valid;
          o_read_ack  <= s1_read;
          o_write_ack <= s1_write;
          o_err       <= s1_err;
          if (s1_valid & s1_read) o_rdata <= s1_data;
        end
      end
    end
  endgenerate

endmodule
